// File: rtl/xaui_tx_idle_gen_if.sv
// XAUI transmit idle generator bus: XGMII column in, pre-encode code groups out.
interface xaui_tx_idle_gen_if;
    logic [31:0] xgmii_txd;
    logic [3:0]  xgmii_txc;
    logic        force_idle;
    logic [31:0] txdata;
    logic [3:0]  txcharisk;
    logic        a_sent;

    modport master (
        output xgmii_txd, xgmii_txc, force_idle,
        input  txdata, txcharisk, a_sent
    );

    modport slave (
        input  xgmii_txd, xgmii_txc, force_idle,
        output txdata, txcharisk, a_sent
    );
endinterface

// File: rtl/xaui_tx_idle_gen.sv
// XAUI transmit idle generator: converts XGMII columns into 8b/10b pre-encode
// code groups, replacing idle columns with ||A||/||K||/||R|| sequences.
// Optional macro XAUI_TX_IDLE_RANDOM_EN enables the PRBS that randomises
// ||K||/||R|| choice and the ||A|| spacing; without it non-A idles are ||K||
// and ||A|| columns are spaced a fixed 17 columns apart.
module xaui_tx_idle_gen (
    input  logic               clk,
    input  logic               reset,
    xaui_tx_idle_gen_if.slave  bus
);
    localparam logic [7:0]  CH_K    = 8'hBC;
    localparam logic [7:0]  CH_A    = 8'h7C;
    localparam logic [7:0]  CH_E    = 8'hFE;
    localparam logic [31:0] COL_K   = {4{CH_K}};
    localparam logic [31:0] COL_A   = {4{CH_A}};
    localparam logic [31:0] COL_IDL = 32'h07070707;
    localparam logic [4:0]  A_BASE  = 5'd16;

    logic [31:0] txdata_q, txdata_d;
    logic [3:0]  txcharisk_q, txcharisk_d;
    logic        a_sent_q, a_sent_d;
    logic [4:0]  a_cnt_q, a_cnt_d;
    logic        prev_idle_q, prev_idle_d;
    logic        col_idle;
    logic        idle_pick_k;
    logic [4:0]  a_reload;
    logic [31:0] data_col;
    logic [3:0]  k_col;

`ifdef XAUI_TX_IDLE_RANDOM_EN
    logic [6:0] prbs_q, prbs_d;

    // x^7+x^6+1 LFSR, free-running every cycle regardless of traffic
    always_comb begin
        prbs_d      = {prbs_q[5:0], prbs_q[6] ^ prbs_q[5]};
        idle_pick_k = prbs_q[0];
        a_reload    = A_BASE + {1'b0, prbs_q[3:0]};
    end

    // PRBS state register
    always_ff @(posedge clk) begin
        if (reset) prbs_q <= 7'h7F;
        else       prbs_q <= prbs_d;
    end
`else
    // Without randomisation the idle stream is K-only with fixed A spacing
    always_comb begin
        idle_pick_k = 1'b1;
        a_reload    = A_BASE;
    end
`endif

    // Per-lane translation of a data/control column
    always_comb begin
        data_col = '0;
        k_col    = '0;
        for (int i = 0; i < 4; i++) begin
            data_col[8*i +: 8] = bus.xgmii_txd[8*i +: 8];
            k_col[i]           = bus.xgmii_txc[i];
            if (bus.xgmii_txc[i]) begin
                case (bus.xgmii_txd[8*i +: 8])
                    8'hFB, 8'hFD, 8'hFE, 8'h9C: ;
                    // idles trailing a /T/ become /K/
                    8'h07:   data_col[8*i +: 8] = CH_K;
                    default: data_col[8*i +: 8] = CH_E;
                endcase
            end
        end
    end

    // Column classification, idle code selection and ||A|| countdown
    always_comb begin
        col_idle    = bus.force_idle ||
                      (bus.xgmii_txc == 4'hF && bus.xgmii_txd == COL_IDL);
        txdata_d    = data_col;
        txcharisk_d = k_col;
        a_sent_d    = 1'b0;
        a_cnt_d     = (a_cnt_q == 5'd0) ? 5'd0 : a_cnt_q - 5'd1;
        prev_idle_d = col_idle;
        if (col_idle) begin
            txcharisk_d = 4'hF;
            if (a_cnt_q == 5'd0) begin
                txdata_d = COL_A;
                a_sent_d = 1'b1;
                a_cnt_d  = a_reload;
            end else if (!prev_idle_q || idle_pick_k) begin
                // ||R|| must never directly follow a non-idle column
                txdata_d = COL_K;
            end else begin
                txdata_d = {4{8'h1C}};
            end
        end
    end

    // Output and state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            txdata_q    <= COL_K;
            txcharisk_q <= 4'hF;
            a_sent_q    <= 1'b0;
            a_cnt_q     <= A_BASE;
            prev_idle_q <= 1'b0;
        end else begin
            txdata_q    <= txdata_d;
            txcharisk_q <= txcharisk_d;
            a_sent_q    <= a_sent_d;
            a_cnt_q     <= a_cnt_d;
            prev_idle_q <= prev_idle_d;
        end
    end

    assign bus.txdata    = txdata_q;
    assign bus.txcharisk = txcharisk_q;
    assign bus.a_sent    = a_sent_q;
endmodule

// File: tb/tb_xaui_tx_idle_gen.sv
// Self-checking bench for xaui_tx_idle_gen: table vectors, directed corner
// sequences and a randomized run against a column-level reference model.
module tb_xaui_tx_idle_gen;
    localparam logic [31:0] IDL = 32'h07070707;
    localparam logic [31:0] CK  = 32'hBCBCBCBC;
    localparam logic [31:0] CA  = 32'h7C7C7C7C;
    localparam logic [31:0] CR  = 32'h1C1C1C1C;

    logic clk = 1'b0;
    logic reset;
    xaui_tx_idle_gen_if bus();

    xaui_tx_idle_gen dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: column index since reset, first column index at
    // which an ||A|| is due, and whether the last column carried data.
    int         mdl_n;
    int         mdl_due;
    bit         mdl_prev_data;
    logic [6:0] prbs_tab [127];

    typedef struct {
        logic [31:0] d;
        logic [3:0]  c;
        logic [31:0] ed;
        logic [3:0]  ek;
    } vec_t;
    vec_t tab [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic random_en();
`ifdef XAUI_TX_IDLE_RANDOM_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_col(input logic [31:0] d, input logic [3:0] c, input logic fi,
                             input logic r, output logic [31:0] ed, output logic [3:0] ek,
                             output logic ea);
        logic [6:0] p;
        bit idle;
        ea = 1'b0;
        if (r) begin
            ed = CK; ek = 4'hF;
            mdl_n = 0; mdl_due = 16; mdl_prev_data = 1'b1;
            return;
        end
        idle = fi || (c == 4'hF && d == IDL);
        p = prbs_tab[mdl_n % 127];
        if (idle) begin
            ek = 4'hF;
            if (mdl_n >= mdl_due) begin
                ed = CA; ea = 1'b1;
                mdl_due = mdl_n + 1 + 16 + (random_en() ? int'(p[3:0]) : 0);
            end else if (mdl_prev_data || !random_en() || p[0]) ed = CK;
            else ed = CR;
        end else begin
            for (int i = 0; i < 4; i++) begin
                logic [7:0] b;
                b = d[8*i +: 8];
                ek[i] = c[i];
                if (!c[i]) ed[8*i +: 8] = b;
                else if (b == 8'hFB || b == 8'hFD || b == 8'hFE || b == 8'h9C) ed[8*i +: 8] = b;
                else if (b == 8'h07) ed[8*i +: 8] = 8'hBC;
                else ed[8*i +: 8] = 8'hFE;
            end
        end
        mdl_prev_data = !idle;
        mdl_n++;
    endtask

    // One column: drive, clock, compare against model
    task automatic col(input logic [31:0] d, input logic [3:0] c, input logic fi, input logic r);
        logic [31:0] ed; logic [3:0] ek; logic ea;
        bus.xgmii_txd = d; bus.xgmii_txc = c; bus.force_idle = fi; reset = r;
        model_col(d, c, fi, r, ed, ek, ea);
        @(posedge clk); #1;
        chk("txdata", bus.txdata, ed);
        chk("txcharisk", {28'd0, bus.txcharisk}, {28'd0, ek});
        chk("a_sent", {31'd0, bus.a_sent}, {31'd0, ea});
    endtask

    initial begin
        logic [6:0] p;
        int first_a, last_a, n_a, n_r;
        p = 7'h7F;
        for (int i = 0; i < 127; i++) begin
            prbs_tab[i] = p;
            p = {p[5:0], p[6] ^ p[5]};
        end
        // lane 0 is bits [7:0]; the start column carries /S/ in lane 0
        tab[0] = '{32'h113C2233, 4'b0100, 32'h11FE2233, 4'b0100};
        tab[1] = '{32'h9CFEFDFB, 4'hF,    32'h9CFEFDFB, 4'hF};
        tab[2] = '{32'h07123456, 4'b1000, 32'hBC123456, 4'b1000};
        tab[3] = '{32'hDEADBEEF, 4'h0,    32'hDEADBEEF, 4'h0};
        tab[4] = '{32'h07070707, 4'b0111, 32'h07BCBCBC, 4'b0111};
        tab[5] = '{32'h555555FB, 4'b0001, 32'h555555FB, 4'b0001};
        tab[6] = '{32'h55555555, 4'h0,    32'h55555555, 4'h0};
        tab[7] = '{32'h070707FD, 4'hF,    32'hBCBCBCFD, 4'hF};

        bus.xgmii_txd = IDL; bus.xgmii_txc = 4'hF; bus.force_idle = 1'b0; reset = 1'b1;

        // reset held 3 cycles (force_idle high must not matter), then idle
        for (int i = 0; i < 3; i++) col(IDL, 4'hF, 1'b1, 1'b1);
        first_a = -1;
        for (int i = 0; i < 40; i++) begin
            col(IDL, 4'hF, 1'b0, 1'b0);
            if (i == 0) chk("first_idle_is_K", bus.txdata, CK);
            if (bus.a_sent && first_a < 0) first_a = i + 1;
        end
        chk("first_A_output_cycle", first_a, 17);

        // table vectors, ending in a /S/ data /T/ frame
        col(IDL, 4'hF, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            col(tab[i].d, tab[i].c, 1'b0, 1'b0);
            chk("tab_txdata", bus.txdata, tab[i].ed);
            chk("tab_charisk", {28'd0, bus.txcharisk}, {28'd0, tab[i].ek});
        end
        col(IDL, 4'hF, 1'b0, 1'b0);
        chk("idle_after_T_not_R", {31'd0, bus.txdata == CR}, 32'd0);

        // a_cnt expires inside a 40-column burst; A waits for the first idle
        col(IDL, 4'hF, 1'b0, 1'b1);
        col(IDL, 4'hF, 1'b0, 1'b0);
        col(IDL, 4'hF, 1'b0, 1'b0);
        n_a = 0;
        for (int i = 0; i < 40; i++) begin
            col($urandom, 4'h0, 1'b0, 1'b0);
            n_a += int'(bus.a_sent);
        end
        chk("no_A_in_burst", n_a, 0);
        col(IDL, 4'hF, 1'b0, 1'b0);
        chk("A_after_burst", bus.txdata, CA);
        chk("A_after_burst_pulse", {31'd0, bus.a_sent}, 32'd1);

        // reset mid-frame drops the frame and restarts the counters
        col(32'h555555FB, 4'b0001, 1'b0, 1'b0);
        col(32'h12345678, 4'h0, 1'b0, 1'b0);
        col(32'h9ABCDEF0, 4'h0, 1'b0, 1'b1);
        chk("reset_mid_frame_K", bus.txdata, CK);
        col(32'h11223344, 4'h0, 1'b0, 1'b0);
        col(IDL, 4'hF, 1'b0, 1'b0);
        chk("idle_after_reset_drop_K", bus.txdata, CK);

        // force_idle mid-frame: next column is idle following a data column
        col(32'h555555FB, 4'b0001, 1'b0, 1'b0);
        col(32'hA5A5A5A5, 4'h0, 1'b0, 1'b0);
        col(32'h5A5A5A5A, 4'h3, 1'b1, 1'b0);
        chk("force_idle_K", bus.txdata, CK);
        chk("force_idle_charisk", {28'd0, bus.txcharisk}, 32'hF);
        for (int i = 0; i < 20; i++) col($urandom, 4'($urandom), 1'b1, 1'b0);

        // 200 idle columns: A spacing and R presence
        col(IDL, 4'hF, 1'b0, 1'b1);
        last_a = -1; n_r = 0;
        for (int i = 0; i < 200; i++) begin
            col(IDL, 4'hF, 1'b0, 1'b0);
            for (int l = 0; l < 4; l++) n_r += int'(bus.txdata[8*l +: 8] == 8'h1C);
            if (bus.a_sent) begin
                if (last_a >= 0) begin
                    if (random_en())
                        chk("A_spacing_in_range",
                            {31'd0, (i - last_a) >= 17 && (i - last_a) <= 32}, 32'd1);
                    else chk("A_spacing_17", i - last_a, 17);
                end
                last_a = i;
            end
        end
        if (!random_en()) chk("no_R_without_prbs", n_r, 0);

        // randomized traffic against the model
        col(IDL, 4'hF, 1'b0, 1'b1);
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] d; logic [3:0] c; int kind;
            kind = $urandom_range(0, 9);
            d = $urandom; c = 4'($urandom);
            for (int l = 0; l < 4; l++) if ($urandom_range(0, 3) == 0) d[8*l +: 8] = 8'h07;
            if (kind < 5) col(IDL, 4'hF, 1'b0, $urandom_range(0, 199) == 0);
            else if (kind < 9) col(d, c, 1'b0, 1'b0);
            else col(d, c, 1'b1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
